// File: rtl/m_cache_ctrl.sv
// rtl/m_cache_ctrl.sv - miss/refill, write-through and invalidate sequencer for a 32-line direct-mapped cache
module m_cache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_req,
    input  logic             w_wr,
    input  logic [31:0]      w_adr,
    input  logic [31:0]      w_wdata,
    output logic             w_ready,
    output logic [31:0]      w_rdata,
    input  logic             w_flush,
    output logic             w_busy,
    output logic [31:0]      c_adr,
    input  logic             c_hit,
    input  logic [31:0]      c_dout,
    output logic             c_we,
    output logic [4:0]       c_wadr,
    output logic [57:0]      c_wd,
    output logic             m_req,
    output logic             m_wr,
    output logic [31:0]      m_adr,
    output logic [31:0]      m_wdata,
    input  logic             m_ack,
    input  logic [31:0]      m_rdata,
    output logic [CNT_W-1:0] r_hits,
    output logic [CNT_W-1:0] r_miss
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_FLUSH = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      r_state;
    logic [31:0] r_adr;     // word address of the access in flight
    logic [31:0] r_wdata;   // store data of the access in flight
    logic [31:0] r_resp;    // data returned in RESP (0 for stores)
    logic        r_upd;     // store hit the cache: update the line on completion
    logic [4:0]  r_fidx;    // next line to invalidate
    logic        r_mreq;
    logic        r_mwr;

    logic        w_idle;
    logic        w_hit_ld;

    assign w_idle   = (r_state == S_IDLE);
    // A pending flush takes priority, so a hit is only served when no flush is seen
    assign w_hit_ld = w_idle && !w_flush && w_req && !w_wr && c_hit;

    assign c_adr   = w_adr;
    assign w_busy  = !w_idle;
    assign m_req   = r_mreq;
    assign m_wr    = r_mwr;
    assign m_adr   = r_adr;
    assign m_wdata = r_wdata;

    // Sequencer state, transaction latches, memory request and event counters
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= S_IDLE;
            r_adr   <= 32'd0;
            r_wdata <= 32'd0;
            r_resp  <= 32'd0;
            r_upd   <= 1'b0;
            r_fidx  <= 5'd0;
            r_mreq  <= 1'b0;
            r_mwr   <= 1'b0;
            r_hits  <= '0;
            r_miss  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_flush) begin
                        r_fidx  <= 5'd0;
                        r_state <= S_FLUSH;
                    end else if (w_req) begin
                        if (w_wr) begin
                            r_adr   <= {w_adr[31:2], 2'b00};
                            r_wdata <= w_wdata;
                            r_upd   <= c_hit;
                            r_mreq  <= 1'b1;
                            r_mwr   <= 1'b1;
                            r_state <= S_WRITE;
                        end else if (c_hit) begin
                            if (r_hits != CNT_MAX)
                                r_hits <= r_hits + CNT_ONE;
                        end else begin
                            r_adr   <= {w_adr[31:2], 2'b00};
                            r_mreq  <= 1'b1;
                            r_mwr   <= 1'b0;
                            r_state <= S_FILL;
                            if (r_miss != CNT_MAX)
                                r_miss <= r_miss + CNT_ONE;
                        end
                    end
                end
                S_FILL: begin
                    if (m_ack) begin
                        r_resp  <= m_rdata;
                        r_mreq  <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (m_ack) begin
                        r_resp  <= 32'd0;
                        r_mreq  <= 1'b0;
                        r_mwr   <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_FLUSH: begin
                    r_fidx <= r_fidx + 5'd1;
                    if (r_fidx == 5'd31)
                        r_state <= S_IDLE;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // CPU response: zero-latency hits from the array, misses and stores from RESP
    always_comb begin
        w_ready = 1'b0;
        w_rdata = 32'd0;
        if (w_hit_ld) begin
            w_ready = 1'b1;
            w_rdata = c_dout;
        end else if (r_state == S_RESP) begin
            w_ready = 1'b1;
            w_rdata = r_resp;
        end
    end

    // Cache write port: refill on read ack, write-through update on store-hit ack, invalidate sweep
    always_comb begin
        c_we   = 1'b0;
        c_wadr = 5'd0;
        c_wd   = 58'd0;
        case (r_state)
            S_FILL: begin
                if (m_ack) begin
                    c_we   = 1'b1;
                    c_wadr = r_adr[6:2];
                    c_wd   = {1'b1, r_adr[31:7], m_rdata};
                end
            end
            S_WRITE: begin
                if (m_ack && r_upd) begin
                    c_we   = 1'b1;
                    c_wadr = r_adr[6:2];
                    c_wd   = {1'b1, r_adr[31:7], r_wdata};
                end
            end
            S_FLUSH: begin
                c_we   = 1'b1;
                c_wadr = r_fidx;
                c_wd   = 58'd0;
            end
            default: begin
                c_we = 1'b0;
            end
        endcase
    end

endmodule
